display_scan_ctrl: RTL

- Time-multiplexed scan driver for the 4-digit 7-segment display; the source side of the BCD-to-7-segment decoder interface.
- Holds a frame snapshot of four BCD digits, cycles the digit-select code, and presents the selected digit's nibble plus the display enable to the decoder.
- Adds per-digit blinking (alarm/time set mode) and optional leading-zero blanking (hours tens).

---
 rtl/display_scan_if.sv | 22 ++
 rtl/display_scan_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/display_scan_if.sv
// Link between the display scan driver and the BCD-to-7-segment decoder.
// The master side snapshots the digits and drives the select, nibble and enable.
interface display_scan_if;
    logic        disp_on;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic        blank_lz;
    logic        en;
    logic [1:0]  en_2;
    logic [3:0]  num;
    logic        frame_start;

    modport master (
        input  disp_on, digits, blink_mask, blank_lz,
        output en, en_2, num, frame_start
    );

    modport slave (
        output disp_on, digits, blink_mask, blank_lz,
        input  en, en_2, num, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit scan driver: per-frame snapshot, digit select,
// per-digit blinking and optional leading-zero blanking of digit 0.
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250
) (
    input  logic           clk,
    input  logic           rst,
    display_scan_if.master bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 0) ? $clog2(BLINK_DIV + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          phase_q, phase_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   snap_dig_q, snap_dig_d;
    logic [3:0]    snap_mask_q, snap_mask_d;
    logic          snap_lz_q, snap_lz_d;
    logic          en_q, en_d;
    logic [3:0]    num_q, num_d;
    logic          fs_q, fs_d;
    logic          tick;

    // Per-digit views of the snapshot that will be in force after this edge.
    logic [3:0] snap_nib [4];
    logic [3:0] blink_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign snap_nib[gi]  = snap_dig_d[15 - 4*gi -: 4];
            assign blink_sel[gi] = snap_mask_d[3 - gi];
        end
    endgenerate

    assign tick = (pre_q == PRE_MAX);

    always_comb begin
        pre_d       = tick ? '0 : pre_q + 1'b1;
        blk_d       = blk_q;
        phase_d     = phase_q;
        sel_d       = sel_q;
        snap_dig_d  = snap_dig_q;
        snap_mask_d = snap_mask_q;
        snap_lz_d   = snap_lz_q;
        fs_d        = 1'b0;
        if (tick) begin
            sel_d = sel_q + 2'd1;
            if (blk_q == BLK_MAX) begin
                blk_d   = '0;
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + 1'b1;
            end
            // Capture only at the frame wrap so a frame never mixes old and new data.
            if (sel_q == 2'd3) begin
                snap_dig_d  = bus.digits;
                snap_mask_d = bus.blink_mask;
                snap_lz_d   = bus.blank_lz;
                fs_d        = 1'b1;
            end
        end
    end

    always_comb begin
        en_d  = en_q;
        num_d = num_q;
        if (tick) begin
            num_d = snap_nib[sel_d];
            en_d  = bus.disp_on
                  & ~(blink_sel[sel_d] & phase_d)
                  & ~((sel_d == 2'd0) & snap_lz_d & (snap_nib[0] == 4'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            blk_q       <= '0;
            phase_q     <= 1'b0;
            sel_q       <= 2'd0;
            snap_dig_q  <= 16'd0;
            snap_mask_q <= 4'd0;
            snap_lz_q   <= 1'b0;
            en_q        <= 1'b0;
            num_q       <= 4'd0;
            fs_q        <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            blk_q       <= blk_d;
            phase_q     <= phase_d;
            sel_q       <= sel_d;
            snap_dig_q  <= snap_dig_d;
            snap_mask_q <= snap_mask_d;
            snap_lz_q   <= snap_lz_d;
            en_q        <= en_d;
            num_q       <= num_d;
            fs_q        <= fs_d;
        end
    end

    assign bus.en          = en_q;
    assign bus.en_2        = sel_q;
    assign bus.num         = num_q;
    assign bus.frame_start = fs_q;
endmodule
